// File: rtl/lc2k_pkg.sv
// Shared LC2K types: sequencer state and next-PC select encoding.
package lc2k_pkg;

   typedef enum logic [1:0] {
      PC_IDLE   = 2'd0,
      PC_RUN    = 2'd1,
      PC_HALTED = 2'd2
   } pc_state_t;

   typedef enum logic [1:0] {
      SEL_SEQ  = 2'd0,
      SEL_BEQ  = 2'd1,
      SEL_JALR = 2'd2,
      SEL_HOLD = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q, cnt_d;

   // next count: clear wins, increment only below the ceiling
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + W'(1);
   end

   // count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Registered next-PC unit: IDLE/RUN/HALTED FSM, prioritised next-PC select,
// PC register and saturating instruction/cycle statistics.
module pc_sequencer
   import lc2k_pkg::*;
#(
   parameter int          ADDR_W   = 32,
   parameter int          OFFSET_W = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int          CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stall,
   input  logic                beq_taken,
   input  logic [OFFSET_W-1:0] offset,
   input  logic                jalr,
   input  logic [ADDR_W-1:0]   jalr_target,
   input  logic                halt,
   output logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   pc_plus_one,
   output logic                fetch_valid,
   output logic                halted,
   output logic [CNT_W-1:0]    inst_count,
   output logic [CNT_W-1:0]    cycle_count
);

   pc_state_t         state_q, state_d;
   pc_sel_t           sel;
   logic              advance;
   logic              in_run;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] off_ext;

   // sign-extend (or truncate) the branch offset to address width
   assign off_ext     = ADDR_W'(signed'(offset));
   assign pc_plus_one = pc_q + ADDR_W'(1);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= PC_IDLE;
      else       state_q <= state_d;
   end

   // next state: HALTED is only left through reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         PC_IDLE:   if (start) state_d = PC_RUN;
         PC_RUN:    if (halt && !stall) state_d = PC_HALTED;
         PC_HALTED: state_d = PC_HALTED;
         default:   state_d = PC_IDLE;
      endcase
   end

   // FSM outputs and next-PC select; halt > beq > jalr > sequential
   always_comb begin
      in_run      = (state_q == PC_RUN);
      advance     = in_run && !stall;
      fetch_valid = in_run;
      halted      = (state_q == PC_HALTED);
      sel         = SEL_HOLD;
      if (advance) begin
         if (halt)           sel = SEL_HOLD;
         else if (beq_taken) sel = SEL_BEQ;
         else if (jalr)      sel = SEL_JALR;
         else                sel = SEL_SEQ;
      end
   end

   // next-PC mux, all arithmetic wraps at address width
   always_comb begin
      pc_d = pc_q;
      case (sel)
         SEL_SEQ:  pc_d = pc_plus_one;
         SEL_BEQ:  pc_d = pc_plus_one + off_ext;
         SEL_JALR: pc_d = jalr_target;
         default:  pc_d = pc_q;
      endcase
   end

   // PC register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= ADDR_W'(RESET_PC);
      else       pc_q <= pc_d;
   end

   assign pc = pc_q;

   // counters are zero in IDLE; IDLE is only reachable through reset anyway
   sat_counter #(.W(CNT_W)) u_inst_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (advance),
      .clear (state_q == PC_IDLE),
      .count (inst_count)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (in_run),
      .clear (state_q == PC_IDLE),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: two sequencer instances share stimulus. u_a is 32-bit with
// RESET_PC=0x10; u_b is 4-bit address, 3-bit counters for wrap/saturation.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, stall = 1'b0, beq_taken = 1'b0, jalr = 1'b0, halt = 1'b0;
   logic [15:0] offset = '0;
   logic [31:0] jalr_target = '0;

   logic [31:0] pc_a, ppo_a, ic_a, cc_a;
   logic        fv_a, h_a;
   logic [3:0]  pc_b, ppo_b;
   logic [2:0]  ic_b, cc_b;
   logic        fv_b, h_b;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(32), .OFFSET_W(16), .RESET_PC(32'h10), .CNT_W(32)) u_a (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .beq_taken(beq_taken),
      .offset(offset), .jalr(jalr), .jalr_target(jalr_target), .halt(halt),
      .pc(pc_a), .pc_plus_one(ppo_a), .fetch_valid(fv_a), .halted(h_a),
      .inst_count(ic_a), .cycle_count(cc_a)
   );

   pc_sequencer #(.ADDR_W(4), .OFFSET_W(16), .RESET_PC(0), .CNT_W(3)) u_b (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .beq_taken(beq_taken),
      .offset(offset), .jalr(jalr), .jalr_target(jalr_target[3:0]), .halt(halt),
      .pc(pc_b), .pc_plus_one(ppo_b), .fetch_valid(fv_b), .halted(h_b),
      .inst_count(ic_b), .cycle_count(cc_b)
   );

   typedef struct {
      logic        stall;
      logic        beq;
      logic [15:0] off;
      logic        jalr;
      logic [31:0] tgt;
      logic        halt;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic [3:0]  exp_pc_b;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic b, input logic [15:0] o,
                        input logic j, input logic [31:0] t, input logic h);
      stall = s; beq_taken = b; offset = o; jalr = j; jalr_target = t; halt = h;
   endtask

   initial begin
      //         stall beq off       jalr tgt     halt exp_pc  inst b_pc
      vecs[0]  = '{0, 0, 16'h0000, 1, 32'h00, 0, 32'h00, 1,  4'h0};
      vecs[1]  = '{0, 0, 16'h0000, 0, 32'h00, 0, 32'h01, 2,  4'h1};
      vecs[2]  = '{0, 0, 16'h0000, 0, 32'h00, 0, 32'h02, 3,  4'h2};
      vecs[3]  = '{0, 0, 16'h0000, 0, 32'h00, 0, 32'h03, 4,  4'h3};
      vecs[4]  = '{0, 1, 16'hFFFC, 0, 32'h00, 0, 32'h00, 5,  4'h0};
      vecs[5]  = '{0, 1, 16'hFFFF, 0, 32'h00, 0, 32'h00, 6,  4'h0};
      vecs[6]  = '{0, 0, 16'h0000, 0, 32'h00, 0, 32'h01, 7,  4'h1};
      vecs[7]  = '{0, 0, 16'h0000, 0, 32'h00, 0, 32'h02, 8,  4'h2};
      vecs[8]  = '{0, 1, 16'h0005, 1, 32'h40, 0, 32'h08, 9,  4'h8};
      vecs[9]  = '{0, 0, 16'h0000, 1, 32'h40, 0, 32'h40, 10, 4'h0};
      vecs[10] = '{0, 0, 16'h0000, 1, 32'h07, 0, 32'h07, 11, 4'h7};
      vecs[11] = '{1, 0, 16'h0000, 0, 32'h00, 0, 32'h07, 11, 4'h7};
      vecs[12] = '{1, 1, 16'h0003, 1, 32'h55, 0, 32'h07, 11, 4'h7};
      vecs[13] = '{1, 0, 16'h0000, 0, 32'h00, 1, 32'h07, 11, 4'h7};

      // T1: reset state, then IDLE holds with start low
      #12 reset = 1'b0;
      #3;
      chk("rst_pc", pc_a, 32'h10);
      chk("rst_fv", fv_a, 0);
      chk("rst_halted", h_a, 0);
      chk("rst_inst", ic_a, 0);
      chk("rst_cycle", cc_a, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 16'h0003, 1, 32'h99, 0);  // ignored in IDLE
         tick();
      end
      chk("idle_pc", pc_a, 32'h10);
      chk("idle_fv", fv_a, 0);
      chk("idle_cycle", cc_a, 0);
      drive(0, 0, 16'h0, 0, 32'h0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_fv", fv_a, 1);
      chk("start_pc", pc_a, 32'h10);
      chk("start_fv_b", fv_b, 1);

      // T2..T4: table of one-cycle RUN vectors
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].stall, vecs[i].beq, vecs[i].off, vecs[i].jalr, vecs[i].tgt, vecs[i].halt);
         tick();
         chk($sformatf("v%0d_pc", i), pc_a, vecs[i].exp_pc);
         chk($sformatf("v%0d_ppo", i), ppo_a, vecs[i].exp_pc + 32'd1);
         chk($sformatf("v%0d_inst", i), ic_a, vecs[i].exp_inst);
         chk($sformatf("v%0d_cycle", i), cc_a, i + 1);
         chk($sformatf("v%0d_pc_b", i), pc_b, vecs[i].exp_pc_b);
         chk($sformatf("v%0d_cycle_b", i), cc_b, (i + 1 > 7) ? 7 : i + 1);
         chk($sformatf("v%0d_inst_b", i), ic_b, (vecs[i].exp_inst > 7) ? 7 : vecs[i].exp_inst);
      end
      chk("stall_halt_fv", fv_a, 1);
      chk("stall_halt_halted", h_a, 0);

      // T5: 4-bit wrap, then sticky halt
      drive(0, 0, 16'h0, 1, 32'h0F, 0);
      tick();
      chk("wrap_pre_b", pc_b, 4'hF);
      drive(0, 0, 16'h0, 0, 32'h0, 0);
      tick();
      chk("wrap_b", pc_b, 4'h0);
      chk("wrap_ppo_b", ppo_b, 4'h1);
      chk("seq_a", pc_a, 32'h10);
      drive(0, 1, 16'h0004, 0, 32'h0, 1);  // halt overrides beq
      tick();
      chk("halt_halted", h_a, 1);
      chk("halt_fv", fv_a, 0);
      chk("halt_pc", pc_a, 32'h10);
      chk("halt_inst", ic_a, 14);
      chk("halt_cycle", cc_a, 17);
      chk("halt_halted_b", h_b, 1);
      for (int i = 0; i < 4; i++) begin
         start = 1'b1;
         drive(0, i[0], 16'h0002, 1, 32'h33, 0);
         tick();
      end
      start = 1'b0;
      chk("frozen_pc", pc_a, 32'h10);
      chk("frozen_inst", ic_a, 14);
      chk("frozen_cycle", cc_a, 17);
      chk("frozen_halted", h_a, 1);
      chk("frozen_pc_b", pc_b, 4'h0);
      chk("frozen_cycle_b", cc_b, 7);

      // T6: restart, a few advances, then async reset between edges
      reset = 1'b1;
      #2 reset = 1'b0;
      drive(0, 0, 16'h0, 0, 32'h0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("rerun_pc", pc_a, 32'h12);
      chk("rerun_inst", ic_a, 2);
      #3 reset = 1'b1;
      #1;
      chk("async_pc", pc_a, 32'h10);
      chk("async_fv", fv_a, 0);
      chk("async_cycle", cc_a, 0);
      chk("async_inst", ic_a, 0);
      #1 reset = 1'b0;
      drive(0, 1, 16'h0007, 0, 32'h0, 0);
      tick();
      chk("post_rst_pc", pc_a, 32'h10);
      chk("post_rst_fv", fv_a, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
